// File: rtl/issue_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : issue_select_arbiter
// Purpose  : Picks the oldest ready entries of a 16-entry RS for two ALUs and
//            one memory-read port. Dispatch order is kept in an age matrix.
//            Optional stats counters: define ISSUE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module issue_select_arbiter #(
    parameter int NUM_ENT = 16,
    parameter int NUM_ALU = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [1:0]                   disp_valid,
    input  logic [$clog2(NUM_ENT)-1:0]   disp_idx1,
    input  logic [$clog2(NUM_ENT)-1:0]   disp_idx2,
    input  logic [NUM_ENT-1:0]           ent_valid,
    input  logic [NUM_ENT-1:0]           ent_rdy,
    input  logic [NUM_ENT-1:0]           ent_is_mem,
    input  logic [NUM_ALU:0]             fu_rdy,
    input  logic                         mem_done,
    output logic [NUM_ALU:0]             issue_valid,
    output logic [$clog2(NUM_ENT)-1:0]   issue_idx0,
    output logic [$clog2(NUM_ENT)-1:0]   issue_idx1,
    output logic [$clog2(NUM_ENT)-1:0]   issue_idx2,
    output logic [NUM_ENT-1:0]           issue_clear,
    output logic                         mem_busy
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]                  stat_issued,
    output logic [31:0]                  stat_stall
`endif
);

    localparam int c_IDX_W = $clog2(NUM_ENT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } memState_t;

    memState_t                           r_memState;
    logic [NUM_ENT-1:0][NUM_ENT-1:0]     r_age;
    logic [NUM_ENT-1:0][NUM_ENT-1:0]     w_ageNext;
    logic [NUM_ALU:0]                    r_issueValid;
    logic [c_IDX_W-1:0]                  r_idx0;
    logic [c_IDX_W-1:0]                  r_idx1;
    logic [c_IDX_W-1:0]                  r_idx2;
    logic [NUM_ENT-1:0]                  r_issueClear;

    logic [NUM_ENT-1:0] w_dispMask;
    logic [NUM_ENT-1:0] w_cand;
    logic [NUM_ENT-1:0] w_aluSet;
    logic [NUM_ENT-1:0] w_memSet;
    logic [NUM_ENT-1:0] w_alu0Pick;
    logic [NUM_ENT-1:0] w_alu1Pick;
    logic [NUM_ENT-1:0] w_gAlu0;
    logic [NUM_ENT-1:0] w_gAlu1;
    logic [NUM_ENT-1:0] w_gMem;
    logic [NUM_ALU:0]   w_grantValid;

    // age[j][i]=1 means j is older than i; i is oldest in s if no member of s is older
    function automatic logic [NUM_ENT-1:0] oldestOf(
        input logic [NUM_ENT-1:0]              s,
        input logic [NUM_ENT-1:0][NUM_ENT-1:0] age
    );
        logic [NUM_ENT-1:0] res;
        logic               older;
        res = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            older = 1'b0;
            for (int j = 0; j < NUM_ENT; j++) begin
                older = older | (s[j] & age[j][i]);
            end
            res[i] = s[i] & ~older;
        end
        return res;
    endfunction

    function automatic logic [c_IDX_W-1:0] toIdx(input logic [NUM_ENT-1:0] oh);
        logic [c_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (oh[i]) idx = idx | c_IDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        w_dispMask = '0;
        if (disp_valid[0]) w_dispMask[disp_idx1] = 1'b1;
        if (disp_valid[1]) w_dispMask[disp_idx2] = 1'b1;
    end

    // Each allocation: new entry is younger than every currently valid entry
    always_comb begin
        w_ageNext = r_age;
        if (disp_valid[0]) begin
            for (int j = 0; j < NUM_ENT; j++) begin
                w_ageNext[j][disp_idx1] = ent_valid[j] && (j != int'(disp_idx1));
            end
            w_ageNext[disp_idx1] = '0;
        end
        if (disp_valid[1]) begin
            for (int j = 0; j < NUM_ENT; j++) begin
                w_ageNext[j][disp_idx2] = ent_valid[j] && (j != int'(disp_idx2));
            end
            w_ageNext[disp_idx2] = '0;
        end
        if (disp_valid[0] && disp_valid[1]) begin
            w_ageNext[disp_idx1][disp_idx2] = 1'b1;
        end
    end

    // Entries granted last cycle are still valid in the RS until this edge
    assign w_cand     = ent_valid & ent_rdy & ~r_issueClear & ~w_dispMask;
    assign w_aluSet   = w_cand & ~ent_is_mem;
    assign w_memSet   = w_cand & ent_is_mem;
    assign w_alu0Pick = oldestOf(w_aluSet, r_age);
    assign w_alu1Pick = oldestOf(w_aluSet & ~w_alu0Pick, r_age);

    always_comb begin
        w_gAlu0 = '0;
        w_gAlu1 = '0;
        if (fu_rdy[0]) begin
            w_gAlu0 = w_alu0Pick;
            if (fu_rdy[1]) w_gAlu1 = w_alu1Pick;
        end else if (fu_rdy[1]) begin
            w_gAlu1 = w_alu0Pick;
        end
    end

    assign w_gMem       = (r_memState == S_IDLE && fu_rdy[NUM_ALU]) ? oldestOf(w_memSet, r_age) : '0;
    assign w_grantValid = {(|w_gMem), (|w_gAlu1), (|w_gAlu0)};

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_issueValid <= '0;
            r_issueClear <= '0;
            r_age        <= '0;
            r_memState   <= S_IDLE;
            if (!rst_n) begin
                r_idx0 <= '0;
                r_idx1 <= '0;
                r_idx2 <= '0;
            end
        end else begin
            r_age        <= w_ageNext;
            r_issueValid <= w_grantValid;
            r_issueClear <= w_gAlu0 | w_gAlu1 | w_gMem;
            if (w_grantValid[0])       r_idx0 <= toIdx(w_gAlu0);
            if (w_grantValid[1])       r_idx1 <= toIdx(w_gAlu1);
            if (w_grantValid[NUM_ALU]) r_idx2 <= toIdx(w_gMem);
            case (r_memState)
                S_IDLE:  if (w_grantValid[NUM_ALU]) r_memState <= S_BUSY;
                S_BUSY:  if (mem_done)              r_memState <= S_IDLE;
                default: r_memState <= S_IDLE;
            endcase
        end
    end

    assign issue_valid = r_issueValid;
    assign issue_idx0  = r_idx0;
    assign issue_idx1  = r_idx1;
    assign issue_idx2  = r_idx2;
    assign issue_clear = r_issueClear;
    assign mem_busy    = (r_memState == S_BUSY);

`ifdef ISSUE_STATS_EN
    logic [31:0] r_statIssued;
    logic [31:0] r_statStall;

    // Counters survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_statIssued <= '0;
            r_statStall  <= '0;
        end else begin
            r_statIssued <= r_statIssued + 32'($countones(r_issueValid));
            if ((|w_cand) && !(|w_grantValid)) r_statStall <= r_statStall + 32'd1;
        end
    end

    assign stat_issued = r_statIssued;
    assign stat_stall  = r_statStall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_select_arbiter
// Purpose  : Directed vector table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_select_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  disp_valid;
    logic [3:0]  disp_idx1;
    logic [3:0]  disp_idx2;
    logic [15:0] ent_valid;
    logic [15:0] ent_rdy;
    logic [15:0] ent_is_mem;
    logic [2:0]  fu_rdy;
    logic        mem_done;
    logic [2:0]  issue_valid;
    logic [3:0]  issue_idx0;
    logic [3:0]  issue_idx1;
    logic [3:0]  issue_idx2;
    logic [15:0] issue_clear;
    logic        mem_busy;
`ifdef ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic [15:0] valid;
        logic [15:0] rdy;
        logic [15:0] isMem;
        logic [2:0]  fu;
        logic [2:0]  eValid;
        logic [3:0]  e0;
        logic [3:0]  e1;
        logic [3:0]  e2;
        logic [15:0] eClear;
    } vec_t;

    vec_t vecs[10];

    issue_select_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_idx1   (disp_idx1),
        .disp_idx2   (disp_idx2),
        .ent_valid   (ent_valid),
        .ent_rdy     (ent_rdy),
        .ent_is_mem  (ent_is_mem),
        .fu_rdy      (fu_rdy),
        .mem_done    (mem_done),
        .issue_valid (issue_valid),
        .issue_idx0  (issue_idx0),
        .issue_idx1  (issue_idx1),
        .issue_idx2  (issue_idx2),
        .issue_clear (issue_clear),
        .mem_busy    (mem_busy)
`ifdef ISSUE_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOut(input string name, input logic [2:0] eValid, input logic [3:0] e0,
                            input logic [3:0] e1, input logic [3:0] e2,
                            input logic [15:0] eClear, input logic eBusy);
        chk({name, ".valid"}, 32'(issue_valid), 32'(eValid));
        chk({name, ".idx0"},  32'(issue_idx0),  32'(e0));
        chk({name, ".idx1"},  32'(issue_idx1),  32'(e1));
        chk({name, ".idx2"},  32'(issue_idx2),  32'(e2));
        chk({name, ".clear"}, 32'(issue_clear), 32'(eClear));
        chk({name, ".busy"},  32'(mem_busy),    32'(eBusy));
    endtask

    task automatic dispatchOne(input logic [3:0] idx, input logic [15:0] validNow);
        disp_valid = 2'b01;
        disp_idx1  = idx;
        ent_valid  = validNow;
        tick();
        disp_valid = 2'b00;
    endtask

    function automatic vec_t mkVec(input logic [15:0] v, input logic [15:0] r, input logic [15:0] m,
                                   input logic [2:0] f, input logic [2:0] ev, input logic [3:0] e0,
                                   input logic [3:0] e1, input logic [3:0] e2, input logic [15:0] ec);
        vec_t t;
        t.valid = v; t.rdy = r; t.isMem = m; t.fu = f;
        t.eValid = ev; t.e0 = e0; t.e1 = e1; t.e2 = e2; t.eClear = ec;
        return t;
    endfunction

    initial begin
        int order[6];
        logic [15:0] acc;

        // Age order after the setup dispatches: 3 > 10 > 6 > 12 > 1 > 14 (0x544A)
        vecs[0] = mkVec(16'h544A, 16'h544A, 16'h0000, 3'b111, 3'b011, 4'd3,  4'd10, 4'd0,  16'h0408);
        vecs[1] = mkVec(16'h544A, 16'h544A, 16'h0048, 3'b111, 3'b111, 4'd10, 4'd12, 4'd3,  16'h1408);
        vecs[2] = mkVec(16'h544A, 16'h4002, 16'h0000, 3'b010, 3'b010, 4'd10, 4'd1,  4'd3,  16'h0002);
        vecs[3] = mkVec(16'h544A, 16'h4002, 16'h0000, 3'b001, 3'b001, 4'd1,  4'd1,  4'd3,  16'h0002);
        vecs[4] = mkVec(16'h544A, 16'h544A, 16'h544A, 3'b011, 3'b000, 4'd1,  4'd1,  4'd3,  16'h0000);
        vecs[5] = mkVec(16'h544A, 16'h544A, 16'h544A, 3'b100, 3'b100, 4'd1,  4'd1,  4'd3,  16'h0008);
        vecs[6] = mkVec(16'h544A, 16'h5002, 16'h1002, 3'b111, 3'b101, 4'd14, 4'd1,  4'd12, 16'h5000);
        vecs[7] = mkVec(16'h544A, 16'h0000, 16'h0000, 3'b111, 3'b000, 4'd14, 4'd1,  4'd12, 16'h0000);
        vecs[8] = mkVec(16'h0440, 16'hFFFF, 16'h0000, 3'b111, 3'b011, 4'd10, 4'd6,  4'd12, 16'h0440);
        vecs[9] = mkVec(16'h5000, 16'hFFFF, 16'h0000, 3'b110, 3'b010, 4'd10, 4'd12, 4'd12, 16'h1000);

        // T1: reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush      = 1'($urandom);
            disp_valid = 2'($urandom);
            disp_idx1  = 4'($urandom);
            disp_idx2  = 4'($urandom);
            ent_valid  = 16'($urandom);
            ent_rdy    = 16'($urandom);
            ent_is_mem = 16'($urandom);
            fu_rdy     = 3'($urandom);
            mem_done   = 1'($urandom);
            tick();
        end
        checkOut("reset", 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);

        rst_n = 1'b1; flush = 1'b0; disp_valid = 2'b00; disp_idx1 = 4'd0; disp_idx2 = 4'd0;
        ent_valid = '0; ent_rdy = '0; ent_is_mem = '0; fu_rdy = 3'b000; mem_done = 1'b0;

        order = '{3, 10, 6, 12, 1, 14};
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            dispatchOne(4'(order[i]), acc);
            acc = acc | (16'd1 << order[i]);
        end

        for (int i = 0; i < 10; i++) begin
            ent_valid  = vecs[i].valid;
            ent_rdy    = vecs[i].rdy;
            ent_is_mem = vecs[i].isMem;
            fu_rdy     = vecs[i].fu;
            mem_done   = 1'b0;
            tick();
            checkOut($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].e0, vecs[i].e1,
                     vecs[i].e2, vecs[i].eClear, vecs[i].eValid[2]);
            ent_rdy = '0; fu_rdy = 3'b000; mem_done = 1'b1;
            tick();
            mem_done = 1'b0;
        end

        // T2: sequential dispatch 5 then 2
        ent_valid = '0; ent_is_mem = '0;
        dispatchOne(4'd5, 16'h0000);
        dispatchOne(4'd2, 16'h0020);
        ent_valid = 16'h0024; ent_rdy = 16'h0024; fu_rdy = 3'b111;
        tick();
        checkOut("t2_issue", 3'b011, 4'd5, 4'd2, 4'd12, 16'h0024, 1'b0);
        tick();
        checkOut("t2_noreissue", 3'b000, 4'd5, 4'd2, 4'd12, 16'h0000, 1'b0);
        ent_valid = '0; ent_rdy = '0;

        // T3: dual dispatch 9 (older) and 3, only ALU1 ready
        fu_rdy = 3'b010;
        disp_valid = 2'b11; disp_idx1 = 4'd9; disp_idx2 = 4'd3;
        tick();
        disp_valid = 2'b00;
        ent_valid = 16'h0208; ent_rdy = 16'h0208;
        tick();
        checkOut("t3_first", 3'b010, 4'd5, 4'd9, 4'd12, 16'h0200, 1'b0);
        tick();
        checkOut("t3_second", 3'b010, 4'd5, 4'd3, 4'd12, 16'h0008, 1'b0);
        ent_valid = 16'h0008;
        tick();
        checkOut("t3_idle", 3'b000, 4'd5, 4'd3, 4'd12, 16'h0000, 1'b0);
        ent_valid = '0; ent_rdy = '0; fu_rdy = 3'b000;

        // T4: two loads, single outstanding
        disp_valid = 2'b11; disp_idx1 = 4'd1; disp_idx2 = 4'd4;
        tick();
        disp_valid = 2'b00;
        ent_valid = 16'h0012; ent_rdy = 16'h0012; ent_is_mem = 16'h0012; fu_rdy = 3'b111;
        tick();
        checkOut("t4_load1", 3'b100, 4'd5, 4'd3, 4'd1, 16'h0002, 1'b1);
        tick();
        checkOut("t4_wait0", 3'b000, 4'd5, 4'd3, 4'd1, 16'h0000, 1'b1);
        ent_valid = 16'h0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOut($sformatf("t4_wait%0d", i + 1), 3'b000, 4'd5, 4'd3, 4'd1, 16'h0000, 1'b1);
        end
        mem_done = 1'b1;
        tick();
        checkOut("t4_done", 3'b000, 4'd5, 4'd3, 4'd1, 16'h0000, 1'b0);
        mem_done = 1'b0;
        tick();
        checkOut("t4_load2", 3'b100, 4'd5, 4'd3, 4'd4, 16'h0010, 1'b1);

        // T5: flush while BUSY with three ready ALU entries
        ent_valid = 16'h0904; ent_rdy = 16'h0904; ent_is_mem = '0; fu_rdy = 3'b111; flush = 1'b1;
        tick();
        checkOut("t5_flush", 3'b000, 4'd5, 4'd3, 4'd4, 16'h0000, 1'b0);
        flush = 1'b0; ent_valid = '0; ent_rdy = '0; fu_rdy = 3'b000;
        dispatchOne(4'd7, 16'h0000);
        dispatchOne(4'd8, 16'h0080);
        ent_valid = 16'h0180; ent_rdy = 16'h0180; fu_rdy = 3'b001;
        tick();
        checkOut("t5_redisp", 3'b001, 4'd7, 4'd3, 4'd4, 16'h0080, 1'b0);
        ent_valid = '0; ent_rdy = '0; fu_rdy = 3'b000;

`ifdef ISSUE_STATS_EN
        begin
            logic [31:0] s0;
            logic [31:0] i0;
            tick();
            s0 = stat_stall;
            i0 = stat_issued;
            ent_valid = 16'h0180; ent_rdy = 16'h0180;
            for (int i = 0; i < 10; i++) tick();
            chk("t6_stall", stat_stall - s0, 32'd10);
            chk("t6_issued", stat_issued - i0, 32'd0);
            ent_valid = '0; ent_rdy = '0;
        end
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
